// File: rtl/fft_pkg.sv
// Shared constants and twiddle generation for the DIT FFT twiddle multiplier.
package fft_pkg;

   localparam int N_DEF   = 16;
   localparam int TW_DEF  = 16;
   localparam int LOG2N   = $clog2(N_DEF);
   localparam int STAGE_W = $clog2(LOG2N);
   localparam real PI     = 3.14159265358979323846;

   function automatic int f_log2n(input int n);
      return $clog2(n);
   endfunction

   function automatic int f_stage_w(input int n);
      return $clog2($clog2(n));
   endfunction

   function automatic int q_one(input int tw);
      return 1 << (tw - 2);
   endfunction

   function automatic int q_rnd(input int tw);
      return 1 << (tw - 3);
   endfunction

   // Taylor series keeps elaboration free of tool-specific math builtins
   function automatic int tw_coef(input int k, input int n,
                                  input int tw, input bit is_sin);
      real a;
      real term;
      real acc;
      real x;
      a = 2.0 * PI * real'(k) / real'(n);
      term = is_sin ? a : 1.0;
      acc = term;
      for (int i = 1; i < 16; i++) begin
         if (is_sin)
            term = -term * a * a / real'((2 * i) * (2 * i + 1));
         else
            term = -term * a * a / real'((2 * i - 1) * (2 * i));
         acc = acc + term;
      end
      x = acc * real'(q_one(tw));
      if (x >= 0.0)
         return $rtoi(x + 0.5);
      return -$rtoi(0.5 - x);
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Constant cos/sin lookup for W_N^k, k in [0, N/2).
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int N  = 16,
   parameter int TW = 16
) (
   input  logic [$clog2(N/2)-1:0] k,
   output logic signed [TW-1:0]   c,
   output logic signed [TW-1:0]   s
);

   localparam int HALF = N / 2;

   logic signed [TW-1:0] c_tab [HALF];
   logic signed [TW-1:0] s_tab [HALF];

   for (genvar i = 0; i < HALF; i++) begin : g_tab
      localparam int CI = tw_coef(i, N, TW, 1'b0);
      localparam int SI = tw_coef(i, N, TW, 1'b1);
      assign c_tab[i] = TW'(CI);
      assign s_tab[i] = TW'(SI);
   end

   assign c = c_tab[k];
   assign s = s_tab[k];

endmodule

// File: rtl/fft_twiddle_mult.sv
// Three-stage complex twiddle multiplier feeding the radix-2 butterfly adder.
module fft_twiddle_mult
   import fft_pkg::*;
#(
   parameter int bit_width = 16,
   parameter int tw_width  = 16,
   parameter int N         = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [f_stage_w(N)-1:0]     stage,
   input  logic                        in_valid,
   input  logic signed [bit_width-1:0] xin1,
   input  logic signed [bit_width-1:0] yin1,
   input  logic signed [bit_width-1:0] xin2,
   input  logic signed [bit_width-1:0] yin2,
   output logic signed [bit_width-1:0] xout1,
   output logic signed [bit_width-1:0] yout1,
   output logic signed [bit_width-1:0] xout2,
   output logic signed [bit_width-1:0] yout2,
   output logic                        en,
   output logic                        frame_done
);

   localparam int BW   = bit_width;
   localparam int TW   = tw_width;
   localparam int LG   = f_log2n(N);
   localparam int SW   = f_stage_w(N);
   localparam int KW   = LG - 1;
   localparam int PW   = BW + TW;
   localparam int SUMW = PW + 1;

   localparam logic [KW-1:0] J_LAST = KW'(N / 2 - 1);
   localparam logic signed [SUMW-1:0] RND  = SUMW'(q_rnd(TW));
   localparam logic signed [SUMW-1:0] SMAX = SUMW'((1 << (BW - 1)) - 1);
   localparam logic signed [SUMW-1:0] SMIN = -SMAX - SUMW'(1);

   logic [KW-1:0]        j_q, j_d, k, mask;
   logic [SW-1:0]        stage_q, stage_d, s_eff;
   int                   s_i;
   logic signed [TW-1:0] c_rom, s_rom;

   logic signed [TW-1:0] c_q, c_d, s_q, s_d;
   logic signed [BW-1:0] x1a_q, x1a_d, y1a_q, y1a_d;
   logic signed [BW-1:0] x2_q, x2_d, y2_q, y2_d;
   logic signed [BW-1:0] x1b_q, x1b_d, y1b_q, y1b_d;
   logic signed [PW-1:0] xc_q, xc_d, ys_q, ys_d;
   logic signed [PW-1:0] yc_q, yc_d, xs_q, xs_d;
   logic signed [BW-1:0] x1c_q, x1c_d, y1c_q, y1c_d;
   logic signed [BW-1:0] xo2_q, xo2_d, yo2_q, yo2_d;
   logic [2:0]           v_q, v_d, l_q, l_d;

   function automatic logic signed [BW-1:0] rnd_sat(
      input logic signed [SUMW-1:0] v);
      logic signed [SUMW-1:0] r;
      r = (v + RND) >>> (TW - 2);
      if (r > SMAX)
         return SMAX[BW-1:0];
      if (r < SMIN)
         return SMIN[BW-1:0];
      return r[BW-1:0];
   endfunction

   twiddle_rom #(.N(N), .TW(TW)) u_rom (
      .k (k),
      .c (c_rom),
      .s (s_rom)
   );

   // First pair of a frame indexes with the live stage input
   always_comb begin
      s_eff = (j_q == '0) ? stage : stage_q;
      s_i = int'(s_eff);
      if (s_i > KW)
         s_i = KW;
      mask = ~({KW{1'b1}} << s_i);
      k = (j_q & mask) << (KW - s_i);
   end

   always_comb begin
      j_d     = j_q;
      stage_d = stage_q;
      if (in_valid) begin
         j_d = (j_q == J_LAST) ? '0 : j_q + KW'(1);
         if (j_q == '0)
            stage_d = stage;
      end

      v_d = {v_q[1:0], in_valid};
      l_d = {l_q[1:0], in_valid && (j_q == J_LAST)};

      x1a_d = xin1;
      y1a_d = yin1;
      x2_d  = xin2;
      y2_d  = yin2;
      c_d   = c_rom;
      s_d   = s_rom;

      x1b_d = x1a_q;
      y1b_d = y1a_q;
      xc_d  = PW'(x2_q) * PW'(c_q);
      ys_d  = PW'(y2_q) * PW'(s_q);
      yc_d  = PW'(y2_q) * PW'(c_q);
      xs_d  = PW'(x2_q) * PW'(s_q);

      x1c_d = x1b_q;
      y1c_d = y1b_q;
      xo2_d = rnd_sat(SUMW'(xc_q) + SUMW'(ys_q));
      yo2_d = rnd_sat(SUMW'(yc_q) - SUMW'(xs_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_q     <= '0;
         stage_q <= '0;
         v_q     <= '0;
         l_q     <= '0;
         x1a_q   <= '0;
         y1a_q   <= '0;
         x2_q    <= '0;
         y2_q    <= '0;
         c_q     <= '0;
         s_q     <= '0;
         x1b_q   <= '0;
         y1b_q   <= '0;
         xc_q    <= '0;
         ys_q    <= '0;
         yc_q    <= '0;
         xs_q    <= '0;
         x1c_q   <= '0;
         y1c_q   <= '0;
         xo2_q   <= '0;
         yo2_q   <= '0;
      end else begin
         j_q     <= j_d;
         stage_q <= stage_d;
         v_q     <= v_d;
         l_q     <= l_d;
         x1a_q   <= x1a_d;
         y1a_q   <= y1a_d;
         x2_q    <= x2_d;
         y2_q    <= y2_d;
         c_q     <= c_d;
         s_q     <= s_d;
         x1b_q   <= x1b_d;
         y1b_q   <= y1b_d;
         xc_q    <= xc_d;
         ys_q    <= ys_d;
         yc_q    <= yc_d;
         xs_q    <= xs_d;
         x1c_q   <= x1c_d;
         y1c_q   <= y1c_d;
         xo2_q   <= xo2_d;
         yo2_q   <= yo2_d;
      end
   end

   assign xout1      = x1c_q;
   assign yout1      = y1c_q;
   assign xout2      = xo2_q;
   assign yout2      = yo2_q;
   assign en         = v_q[2];
   assign frame_done = l_q[2];

endmodule

// File: doc/fft_twiddle_mult.md
# fft_twiddle_mult

Pipelined complex twiddle multiplier that sits directly upstream of the radix-2 butterfly adder in the parallel decimation-in-time FFT. Each valid input is one butterfly pair: a top sample (x1, y1) and a bottom sample (x2, y2). The block multiplies the bottom sample by W_N^k, generating k internally from a butterfly counter and the current stage number. It then delivers the aligned pair, with an enable strobe, to the adder.

## Interface
- `bit_width`, 16: sample width, signed real and imaginary parts.
- `tw_width`, 16: twiddle width, signed Q2.(tw_width-2), so 1.0 = 2^(tw_width-2).
- `N`, 16: FFT length, a power of two, at least 4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stage` input clog2(clog2(N)): DIT stage s, from 0 to log2(N)-1.
- `in_valid` input 1: one butterfly pair is presented this cycle.
- `xin1`, `yin1` input bit_width each: top sample. Passed through unchanged.
- `xin2`, `yin2` input bit_width each: bottom sample. Multiplied by W.
- `xout1`, `yout1` output bit_width each: delayed top sample.
- `xout2`, `yout2` output bit_width each: bottom sample times W, rounded and saturated.
- `en` output 1: output valid. Drives the adder enable.
- `frame_done` output 1: one-cycle pulse, coincident with `en` for the last pair of a stage (pair N/2-1).

## Operation
- Twiddle: W^k = cos(2πk/N) − j·sin(2πk/N), for k from 0 to N/2-1.
  - Held in a constant ROM of c = round(cos·2^(tw_width-2)) and s = round(sin·2^(tw_width-2)).
- Butterfly counter j:
  - Range 0 to N/2-1. Increments on each `in_valid`. Wraps to 0 after N/2-1.
- Stage register:
  - `stage` is captured into `stage_q` on an `in_valid` where j == 0.
  - A change to `stage` mid-frame has no effect until the next frame start.
- Index: k = (j mod 2^s) · (N >> (s+1)), where s is the captured stage.
  - For the first pair of a frame, k uses the incoming `stage` directly.
- Product: (x2 + j·y2)(c − j·s).
  - Real part: re = x2·c + y2·s.
  - Imaginary part: im = y2·c − x2·s.
  - Each product is bit_width+tw_width bits. Each sum is bit_width+tw_width+1 bits.
- Rounding: add 2^(tw_width-3), then arithmetic right shift by tw_width-2 (round half up).
- Saturation: clamp to [−2^(bit_width-1), 2^(bit_width-1)−1].
- Top sample (x1, y1) is delayed through matching registers only. No arithmetic is applied to it.
- No backpressure: a new pair may be accepted every cycle, and gaps in `in_valid` are allowed.

## Timing
- Latency is exactly 3 cycles from `in_valid` to `en`. Full throughput, one pair per cycle.
  - P1: register inputs, k, and the ROM output (c, s).
  - P2: register the four products.
  - P3: register the sums after round and saturate. Drive outputs and `en`.
- The valid bit and the last-pair flag travel down a 3-deep shift register, which produces `en` and `frame_done`.
- All outputs are registered.
- Reset values:
  - All data outputs are 0; `en` and `frame_done` are 0.
  - j = 0, `stage_q` = 0, and every pipeline valid bit is 0.
- Asserting `rst_n` low mid-frame has the following effects:
  - In-flight pairs are discarded. No `en` is produced for them after release.
  - The next `in_valid` after release is treated as j = 0.
- `in_valid` on the wrap cycle (j = N/2-1):
  - That pair is processed normally and is flagged last.
  - The following `in_valid` begins a new frame and recaptures `stage`.

## Structure
- Shared package `fft_pkg`:
  - `log2N` and the `stage` width.
  - The twiddle ROM generation function.
  - The Q-format constants: ONE = 2^(tw_width-2) and the rounding constant.
- Sub-module `twiddle_rom`: combinational lookup from k (clog2(N/2) bits) to c and s, registered in P1 by the parent.
- The parent holds the counter, the stage capture, the index computation, and the 3-stage datapath and valid pipeline.

## Test plan
All scenarios use the default parameters.
- Stage 0, W^0: x2 = 1000, y2 = −500 → xout2 = 1000, yout2 = −500, 3 cycles later. x1/y1 = 7/−7 arrive unchanged.
- Stage 3, j = 4 (k = 4, W = −j): x2 = 1000, y2 = 0 → xout2 = 0, yout2 = −1000.
- Saturation, stage 3, j = 2 (k = 2, c = s = 11585): x2 = y2 = −32768.
  - Expected: xout2 = −32768 (saturated from −46340), yout2 = 0.
- Index sequence:
  - Stage 2, 8 back-to-back pairs → k = 0, 2, 4, 6, 0, 2, 4, 6, checked through output values. `frame_done` on the 8th `en` only.
  - Stage 1 → k = 0, 4, 0, 4, …
- Gapped valid, with `stage` changed mid-frame:
  - `en` pattern equals the `in_valid` pattern delayed by 3 cycles.
  - Old stage is used until the wrap. The new stage is used from the next frame.
- Reset mid-frame (`rst_n` low at j = 5 with 2 pairs in flight):
  - No `en` appears after release.
  - The next pair uses k = 0 and `frame_done` follows 8 pairs later.
